// File: rtl/tdm_demux_4ch.sv
// Receive end of a 4:1 TDM link: realigns on the frame marker, reassembles four
// slots into parallel channel registers and feeds the slot select back upstream.
module tdm_demux_4ch #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             frame,
    input  logic [WIDTH-1:0] d,
    input  logic             err_clr,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             valid,
    output logic             sync_err
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state_r;
    logic [1:0]       cnt_r;
    logic [WIDTH-1:0] shadow0_r;
    logic [WIDTH-1:0] shadow1_r;
    logic [WIDTH-1:0] shadow2_r;
    logic [WIDTH-1:0] o0_r;
    logic [WIDTH-1:0] o1_r;
    logic [WIDTH-1:0] o2_r;
    logic [WIDTH-1:0] o3_r;
    logic             valid_r;
    logic             sync_err_r;
    logic             misaligned_s;

    // A marker landing anywhere but slot 0 after lock means the link slipped.
    assign misaligned_s = en & frame & (state_r == LOCKED) & (cnt_r != 2'd0);

    // Lock FSM, slot counter, shadow capture, frame publish and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= UNLOCKED;
            cnt_r      <= 2'd0;
            shadow0_r  <= {WIDTH{1'b0}};
            shadow1_r  <= {WIDTH{1'b0}};
            shadow2_r  <= {WIDTH{1'b0}};
            o0_r       <= {WIDTH{1'b0}};
            o1_r       <= {WIDTH{1'b0}};
            o2_r       <= {WIDTH{1'b0}};
            o3_r       <= {WIDTH{1'b0}};
            valid_r    <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            // A fresh misalignment overrides a simultaneous clear.
            if (misaligned_s) begin
                sync_err_r <= 1'b1;
            end else if (err_clr) begin
                sync_err_r <= 1'b0;
            end else begin
                sync_err_r <= sync_err_r;
            end

            if (en) begin
                if (frame) begin
                    state_r   <= LOCKED;
                    shadow0_r <= d;
                    cnt_r     <= 2'd1;
                end else begin
                    case (state_r)
                        LOCKED: begin
                            cnt_r <= cnt_r + 2'd1;
                            case (cnt_r)
                                2'd0: shadow0_r <= d;
                                2'd1: shadow1_r <= d;
                                2'd2: shadow2_r <= d;
                                2'd3: begin
                                    // Slot 3 goes straight to its output, no shadow needed.
                                    o0_r    <= shadow0_r;
                                    o1_r    <= shadow1_r;
                                    o2_r    <= shadow2_r;
                                    o3_r    <= d;
                                    valid_r <= 1'b1;
                                end
                                default: cnt_r <= 2'd0;
                            endcase
                        end
                        UNLOCKED: cnt_r <= 2'd0;
                        default: begin
                            state_r <= UNLOCKED;
                            cnt_r   <= 2'd0;
                        end
                    endcase
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign s0       = cnt_r[0];
    assign s1       = cnt_r[1];
    assign o0       = o0_r;
    assign o1       = o1_r;
    assign o2       = o2_r;
    assign o3       = o3_r;
    assign valid    = valid_r;
    assign sync_err = sync_err_r;

endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive end of a 4:1 multiplexed serial link. One sample per enabled clock arrives on `d` in slot order 0,1,2,3. A frame marker aligns slot 0. The block reassembles each complete frame into four parallel channel registers and publishes them together with a one-cycle `valid` pulse. It also drives the slot select `{s1,s0}` back to the upstream 4:1 multiplexer, so both ends stay in step.

## Interface

- `WIDTH`, default 1: bit width of each channel sample.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  sample strobe; `d` and `frame` are only examined on cycles with `en`=1.
- `frame`  input  1  start-of-frame marker; high with `en` means `d` carries slot 0.
- `d`  input  WIDTH  serial sample stream.
- `err_clr`  input  1  synchronous clear of `sync_err`.
- `s0`  output  1  LSB of the expected slot index for the next enabled sample.
- `s1`  output  1  MSB of the expected slot index for the next enabled sample.
- `o0`  output  WIDTH  channel 0, from the last complete frame.
- `o1`  output  WIDTH  channel 1, from the last complete frame.
- `o2`  output  WIDTH  channel 2, from the last complete frame.
- `o3`  output  WIDTH  channel 3, from the last complete frame.
- `valid`  output  1  one-cycle pulse; `o0`..`o3` were updated on this edge.
- `sync_err`  output  1  sticky flag: `frame` seen at a slot other than 0 while LOCKED.

## Operation

- **State machine:** two states, UNLOCKED and LOCKED.
  - Reset enters UNLOCKED.
  - UNLOCKED: enabled samples with `frame`=0 are discarded; `cnt` holds 0.
  - UNLOCKED → LOCKED: on `en`=1 with `frame`=1.
  - LOCKED has no exit except reset.
- **Slot counter `cnt`:** 2 bits, unsigned. `{s1,s0}` = `cnt`, driven directly from the register.
- **LOCKED, `en`=1, `frame`=0:**
  - `shadow[cnt]` <= `d`; `cnt` <= `cnt`+1 (modulo 4, so 3 wraps to 0).
  - If `cnt`==3: `o0`<=shadow0, `o1`<=shadow1, `o2`<=shadow2, `o3`<=`d`, and `valid`<=1.
- **`en`=1, `frame`=1, either state:**
  - `shadow0` <= `d`; `cnt` <= 1.
  - If LOCKED and `cnt`!=0: `sync_err`<=1, and the partial frame is discarded (no `valid`, outputs unchanged).
  - Frame with `cnt`==0 in LOCKED is legal and flags nothing.
- **`en`=0:**
  - All state holds and `valid`=0.
  - `frame` and `d` are ignored.
- **Error flag:**
  - `err_clr`=1 clears `sync_err` on the next edge.
  - If a new error and `err_clr` occur in the same cycle, set wins and `sync_err` stays 1.
- **Reset:**
  - Clears `cnt`, shadows, `o0`..`o3`, `valid` and `sync_err` to 0, and returns to UNLOCKED.
  - Reset mid-frame loses the partial frame; a new `frame` is needed before any further `valid`.

## Timing

- Reset values: `s0`=0, `s1`=0, `o0`..`o3`=0, `valid`=0, `sync_err`=0.
- Latency: `o0`..`o3` and `valid` change on the same edge that samples slot 3. They are visible in the cycle after the slot-3 sample cycle.
- Minimum frame period is 4 enabled cycles, so `valid` rises at most once per 4 cycles.
- `valid` is high for exactly one cycle. Outputs hold until the next complete frame.
- Upstream contract: the upstream mux presents `i[{s1,s0}]` on `d` in the same cycle. `{s1,s0}` is a registered output, so there is no combinational path from `d` or `frame`.
- `sync_err` rises on the edge after the misplaced `frame` cycle.
- `en` gaps inside a frame are legal and stretch the frame without corrupting it.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream. All outputs go to 0 immediately (asynchronous). After release, with `frame`=0 and `en`=1, `d`=1 for 8 cycles: no `valid`, and `{s1,s0}` stays 0.
- **Basic frame:** WIDTH=4, `en`=1; `frame`=1 with `d`=A, then `d`=5, C, 3. One cycle after `d`=3, `o0`..`o3` = A,5,C,3, `valid`=1 for one cycle, and `{s1,s0}` sequence = 0,1,2,3,0.
- **Back-to-back frames:** frames 1,2,3,4 then 8,9,A,B, with `frame` on every 4th cycle. `valid` pulses exactly 4 cycles apart, outputs update accordingly, and `sync_err` stays 0.
- **Enable gaps:** frame 1,2,3,4 with `en`=0 for 3 cycles between slots 1 and 2. Outputs are 1,2,3,4, `valid` is delayed by exactly 3 cycles, and `{s1,s0}` holds at 2 during the gap.
- **Misalignment:** `frame` at slot 2 of frame F,F,F,x. `sync_err`=1 on the next edge, there is no `valid` for the partial frame, and the new frame completes normally. Then `err_clr`=1 together with another misaligned `frame`: `sync_err` stays 1. `err_clr`=1 alone: `sync_err`=0.
- **Loopback:** drive a behavioural 4:1 mux (i0..i3 = 1,0,1,1, WIDTH=1) from `{s1,s0}` with `frame`=(`cnt`==0). `o0`..`o3` = 1,0,1,1 on every `valid`.
